// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply datapath.
// Holds the controller state encoding and the default accumulator width rule.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The full K-term sum of DATAWIDTH x DATAWIDTH products fits without wrapping.
    function automatic int accw_default(input int dw, input int k);
        return 2 * dw + $clog2(k);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: registered a/b pass-through and a wrapping
// multiply-accumulate with a sticky carry-out flag.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ACCW      = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DATAWIDTH-1:0] a_in,
    input  logic [DATAWIDTH-1:0] b_in,
    output logic [DATAWIDTH-1:0] a_out,
    output logic [DATAWIDTH-1:0] b_out,
    output logic [ACCW-1:0]      acc,
    output logic                 ovf
);

    // Returns {carry, sum}; the product is zero-extended before the add.
    function automatic logic [ACCW:0] mac_wrap(
        input logic [ACCW-1:0]      base,
        input logic [DATAWIDTH-1:0] a,
        input logic [DATAWIDTH-1:0] b
    );
        logic [2*DATAWIDTH-1:0] prod;
        prod = {{DATAWIDTH{1'b0}}, a} * {{DATAWIDTH{1'b0}}, b};
        return {1'b0, base} + {{(ACCW + 1 - 2 * DATAWIDTH){1'b0}}, prod};
    endfunction

    logic [ACCW:0] sum;

    always_comb begin
        sum = mac_wrap(acc, a_in, b_in);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (en) begin
                acc <= sum[ACCW-1:0];
                if (sum[ACCW]) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/systolic_matmul_param.sv
// Output-stationary NxN systolic multiplier C = A(NxK) * B(KxN) with internal operand
// skew, valid/ready beat intake, accumulate mode and a sticky overflow flag.
module systolic_matmul_param
    import systolic_pkg::*;
#(
    parameter int N         = 3,
    parameter int K         = 3,
    parameter int DATAWIDTH = 8,
    parameter int ACCW      = accw_default(DATAWIDTH, K)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   acc_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DATAWIDTH-1:0] a_col,
    input  logic [N*DATAWIDTH-1:0] b_row,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [N*N*ACCW-1:0]    p_out
);

    localparam int BCW = (K > 1) ? $clog2(K) : 1;
    localparam int DCW = $clog2(2 * N);
    localparam logic [BCW-1:0] BEAT_LAST  = BCW'(K - 1);
    // One input-register cycle plus 2N-1 cycles of skew and propagation to PE(N-1,N-1).
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 1);

    state_t         state, state_d;
    logic [BCW-1:0] beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           take;
    logic           clr;
    logic           en;

    always_comb begin
        state_d  = state;
        take     = 1'b0;
        clr      = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    clr     = !acc_mode;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                take     = in_valid;
                if (in_valid && (beat_cnt == BEAT_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign en = (state == LOAD) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_d;
            if (state != LOAD) begin
                beat_cnt <= '0;
            end else if (take) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state != DRAIN) begin
                drain_cnt <= '0;
            end else begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    // ---- stage p0: operand capture; bubbles and idle cycles inject zeros ----
    logic [DATAWIDTH-1:0] a_p0 [N];
    logic [DATAWIDTH-1:0] b_p0 [N];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                a_p0[i] <= '0;
                b_p0[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_p0[i] <= take ? a_col[i*DATAWIDTH +: DATAWIDTH] : '0;
                b_p0[i] <= take ? b_row[i*DATAWIDTH +: DATAWIDTH] : '0;
            end
        end
    end

    // ---- skew: row/column i delayed i cycles, then into the grid edge ----
    logic [DATAWIDTH-1:0] a_lnk [N][N+1];
    logic [DATAWIDTH-1:0] b_lnk [N+1][N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_lnk[0][0] = a_p0[0];
            assign b_lnk[0][0] = b_p0[0];
        end else begin : g_delay
            logic [DATAWIDTH-1:0] a_sr [i];
            logic [DATAWIDTH-1:0] b_sr [i];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_p0[i];
                    b_sr[0] <= b_p0[i];
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end

            assign a_lnk[i][0] = a_sr[i-1];
            assign b_lnk[0][i] = b_sr[i-1];
        end
    end

    // ---- PE grid: a flows right along rows, b flows down columns ----
    logic [N*N-1:0] ovf_vec;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DATAWIDTH (DATAWIDTH),
                .ACCW      (ACCW)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .en    (en),
                .a_in  (a_lnk[i][j]),
                .b_in  (b_lnk[i][j]),
                .a_out (a_lnk[i][j+1]),
                .b_out (b_lnk[i+1][j]),
                .acc   (p_out[(i*N+j)*ACCW +: ACCW]),
                .ovf   (ovf_vec[i*N+j])
            );
        end
    end

    assign overflow = |ovf_vec;

endmodule

// File: tb/tb_systolic_matmul_param.sv
// Directed bench for systolic_matmul_param: N=K=3 with the default accumulator and a
// 16-bit accumulator copy sharing the same stimulus for the wrap/overflow case.
module tb_systolic_matmul_param;

    localparam int N  = 3;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int AW = 2 * DW + $clog2(K);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              acc_mode = 1'b0;
    logic              in_valid = 1'b0;
    logic [N*DW-1:0]   a_col = '0;
    logic [N*DW-1:0]   b_row = '0;
    logic              in_ready, busy, done, overflow;
    logic [N*N*AW-1:0] p_out;
    logic              in_ready16, busy16, done16, ovf16;
    logic [N*N*16-1:0] p_out16;

    int n_checks = 0;
    int n_errors = 0;
    int ma [3][3];
    int mb [3][3];
    logic ovf16_at_start;

    int t1m [3][3] = '{'{3, 4, 2}, '{2, 5, 3}, '{3, 2, 5}};
    int t1c [3][3] = '{'{23, 36, 28}, '{25, 39, 34}, '{28, 32, 37}};
    int eye [3][3] = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};

    always #5 clk = ~clk;

    systolic_matmul_param #(.N(N), .K(K), .DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .in_valid(in_valid),
        .in_ready(in_ready), .a_col(a_col), .b_row(b_row), .busy(busy), .done(done),
        .overflow(overflow), .p_out(p_out)
    );

    systolic_matmul_param #(.N(N), .K(K), .DATAWIDTH(DW), .ACCW(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .in_valid(in_valid),
        .in_ready(in_ready16), .a_col(a_col), .b_row(b_row), .busy(busy16), .done(done16),
        .overflow(ovf16), .p_out(p_out16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_mat(input string tag, input int exp [3][3], input bit w16);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                check($sformatf("%s_c%0d%0d", tag, i, j),
                      w16 ? 64'(p_out16[(i*N+j)*16 +: 16]) : 64'(p_out[(i*N+j)*AW +: AW]),
                      64'(exp[i][j]));
            end
        end
    endtask

    // Starts an operation, streams ma/mb one k per beat, and returns the number of
    // edges from the last accepted beat until done is seen (or when aborting mid-drain).
    task automatic run_op(input bit acc, input bit bub, input bit pulse, input bit abort,
                          output int lat);
        int k;
        int guard;
        @(negedge clk);
        start    = 1'b1;
        acc_mode = acc;
        @(negedge clk);
        ovf16_at_start = ovf16;
        k     = 0;
        guard = 0;
        while (k < K && guard < 50) begin
            in_valid = !(bub && (guard % 2 == 0));
            a_col    = {8'(ma[2][k]), 8'(ma[1][k]), 8'(ma[0][k])};
            b_row    = {8'(mb[k][2]), 8'(mb[k][1]), 8'(mb[k][0])};
            start    = pulse;
            @(negedge clk);
            if (in_valid) k++;
            guard++;
        end
        in_valid = 1'b0;
        a_col    = '0;
        b_row    = '0;
        lat      = 0;
        while (!done && lat < 20 && !(abort && lat == 2)) begin
            start = pulse && (lat < 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    int lat;
    int e2 [3][3];
    int e4 [3][3];
    int e4w [3][3];
    bit done_seen;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pout", 64'(p_out), 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_busy16", busy16, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // T1: basic product
        ma = t1m;
        mb = t1m;
        run_op(1'b0, 1'b0, 1'b0, 1'b0, lat);
        check("t1_lat", lat, 6);
        check("t1_done", done, 1'b1);
        check_mat("t1", t1c, 1'b0);
        check("t1_ovf", overflow, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", done, 1'b0);
        check("t1_done16_pulse", done16, 1'b0);

        // T2: accumulate doubles C, then a fresh identity product returns B
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) e2[i][j] = 2 * t1c[i][j];
        run_op(1'b1, 1'b0, 1'b0, 1'b0, lat);
        check("t2_lat", lat, 6);
        check_mat("t2acc", e2, 1'b0);
        ma = eye;
        run_op(1'b0, 1'b0, 1'b0, 1'b0, lat);
        check_mat("t2eye", t1m, 1'b0);

        // T3: bubbles on alternate LOAD cycles
        ma = t1m;
        run_op(1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("t3_lat", lat, 6);
        check_mat("t3", t1c, 1'b0);

        // T4: all-255 operands; 3*65025 = 195075, and 195075 - 2*65536 = 64003
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ma[i][j]  = 255;
                mb[i][j]  = 255;
                e4[i][j]  = 64003;
                e4w[i][j] = 195075;
            end
        end
        run_op(1'b0, 1'b0, 1'b0, 1'b0, lat);
        check("t4_lat", lat, 6);
        check_mat("t4w16", e4, 1'b1);
        check("t4_ovf16", ovf16, 1'b1);
        check_mat("t4w18", e4w, 1'b0);
        check("t4_ovf18", overflow, 1'b0);
        ma = t1m;
        mb = t1m;
        run_op(1'b0, 1'b0, 1'b0, 1'b0, lat);
        check("t4_clr_at_start", ovf16_at_start, 1'b0);
        check("t4_ovf16_after", ovf16, 1'b0);
        check_mat("t4after16", t1c, 1'b1);

        // T5: reset during DRAIN aborts with no done
        run_op(1'b0, 1'b0, 1'b0, 1'b1, lat);
        check("t5_in_drain", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_pout", 64'(p_out), 64'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        rst = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("t5_no_done", done_seen, 1'b0);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, lat);
        check("t5_lat", lat, 6);
        check_mat("t5", t1c, 1'b0);

        // T6: start pulses during LOAD and DRAIN are ignored
        run_op(1'b0, 1'b0, 1'b1, 1'b0, lat);
        check("t6_lat", lat, 6);
        check_mat("t6", t1c, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
